// File: rtl/io_intr_ctrl.sv
// io_intr_ctrl: CPU byte I/O ports plus synchronised, maskable, prioritised interrupts and HLT wake-up
module io_intr_ctrl #(
    parameter int DATA_W = 8,
    parameter int PORT_AW = 1,
    parameter int IRQ_W = 2,
    parameter logic [2**IRQ_W-1:0] IRQ_EDGE = '1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [(2**PORT_AW)*DATA_W-1:0]   in_ports,
    output logic [(2**PORT_AW)*DATA_W-1:0]   out_ports,
    input  logic [2**IRQ_W-1:0]              irq,
    output logic                             hlt_flag,
    input  logic [PORT_AW-1:0]               port_sel,
    input  logic                             out_en,
    input  logic [DATA_W-1:0]                data_from_cpu,
    output logic [DATA_W-1:0]                data_to_cpu,
    input  logic                             hlt_en,
    input  logic                             mask_we,
    input  logic [2**IRQ_W-1:0]              mask_din,
    output logic                             intr_flag,
    output logic [IRQ_W-1:0]                 intr_id,
    input  logic                             intr_ack,
    output logic [2**IRQ_W-1:0]              irq_pending
);
    localparam int N_PORTS = 2**PORT_AW;
    localparam int N_IRQ = 2**IRQ_W;
    logic [N_IRQ-1:0] s1, s2, s3, pending, irq_mask, act, set, clr;
    logic [DATA_W-1:0] in_arr [N_PORTS];
    assign act = pending & irq_mask;
    assign intr_flag = |act;
    assign irq_pending = pending;
    assign set = s2 & ~(s3 & IRQ_EDGE);
    assign clr = (intr_ack && intr_flag) ? {{(N_IRQ-1){1'b0}}, 1'b1} << intr_id : '0;
    // Fixed priority: scanning downward leaves the lowest active index
    always_comb begin
        intr_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (act[i]) intr_id = i[IRQ_W-1:0];
    end
    // Output port registers, each loaded only when addressed by OUT
    for (genvar g = 0; g < N_PORTS; g++) begin : g_port
        assign in_arr[g] = in_ports[g*DATA_W +: DATA_W];
        always_ff @(posedge clk)
            if (rst) out_ports[g*DATA_W +: DATA_W] <= '0;
            else if (out_en && port_sel == PORT_AW'(g)) out_ports[g*DATA_W +: DATA_W] <= data_from_cpu;
    end
    // IN path: selected port sampled every cycle
    always_ff @(posedge clk)
        data_to_cpu <= rst ? '0 : in_arr[port_sel];
    // Synchroniser, edge-detect delay and pending latches; a new set beats an ack clear
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            pending <= '0;
        end else begin
            s1 <= irq;
            s2 <= s1;
            s3 <= s2;
            pending <= (pending & ~clr) | set;
        end
    end
    // Interrupt mask, all lines enabled out of reset
    always_ff @(posedge clk)
        if (rst) irq_mask <= '1;
        else if (mask_we) irq_mask <= mask_din;
    // Halt flag: an enabled pending interrupt always wins over a halt request
    always_ff @(posedge clk)
        hlt_flag <= (rst || intr_flag) ? 1'b0 : (hlt_en ? 1'b1 : hlt_flag);
endmodule

// File: tb/tb_io_intr_ctrl.sv
// tb_io_intr_ctrl: directed and randomized checks of io_intr_ctrl against a behavioural model
module tb_io_intr_ctrl;
    logic clk = 0;
    logic rst = 1;
    logic [15:0] in_ports = 0;
    logic [15:0] out_ports;
    logic [3:0] irq = 0;
    logic hlt_flag;
    logic port_sel = 0;
    logic out_en = 0;
    logic [7:0] data_from_cpu = 0;
    logic [7:0] data_to_cpu;
    logic hlt_en = 0;
    logic mask_we = 0;
    logic [3:0] mask_din = 0;
    logic intr_flag;
    logic [1:0] intr_id;
    logic intr_ack = 0;
    logic [3:0] irq_pending;
    int n_cmp = 0;
    int n_err = 0;

    io_intr_ctrl dut (
        .clk(clk), .rst(rst), .in_ports(in_ports), .out_ports(out_ports), .irq(irq),
        .hlt_flag(hlt_flag), .port_sel(port_sel), .out_en(out_en), .data_from_cpu(data_from_cpu),
        .data_to_cpu(data_to_cpu), .hlt_en(hlt_en), .mask_we(mask_we), .mask_din(mask_din),
        .intr_flag(intr_flag), .intr_id(intr_id), .intr_ack(intr_ack), .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] EDGE = 4'b1111;
    logic m_valid = 0;
    logic [15:0] m_out;
    logic [7:0] m_dtc;
    logic [3:0] m_pend, m_mask;
    logic m_hlt;
    logic [3:0] hist [3];

    function automatic logic [1:0] low_id(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an irq level reaches the pending logic two edges after it is sampled;
    // the edge rule compares it with the level sampled three edges back.
    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1;
            m_out = 0; m_dtc = 0; m_pend = 0; m_mask = 4'hF; m_hlt = 0;
            for (int i = 0; i < 3; i++) hist[i] = 0;
        end else begin
            logic fl;
            logic [1:0] id;
            logic [3:0] nw;
            fl = |(m_pend & m_mask);
            id = low_id(m_pend & m_mask);
            for (int i = 0; i < 4; i++) begin
                nw[i] = EDGE[i] ? (hist[1][i] && !hist[2][i]) : hist[1][i];
                if (nw[i]) m_pend[i] = 1;
                else if (fl && intr_ack && id == 2'(i)) m_pend[i] = 0;
            end
            if (mask_we) m_mask = mask_din;
            if (out_en) m_out[port_sel*8 +: 8] = data_from_cpu;
            m_dtc = in_ports[port_sel*8 +: 8];
            m_hlt = fl ? 0 : (hlt_en ? 1 : m_hlt);
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = irq;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            chk("out_ports", 32'(out_ports), 32'(m_out));
            chk("data_to_cpu", 32'(data_to_cpu), 32'(m_dtc));
            chk("irq_pending", 32'(irq_pending), 32'(m_pend));
            chk("intr_flag", 32'(intr_flag), 32'(|(m_pend & m_mask)));
            chk("intr_id", 32'(intr_id), 32'(low_id(m_pend & m_mask)));
            chk("hlt_flag", 32'(hlt_flag), 32'(m_hlt));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            in_ports = 16'($urandom); irq = 4'($urandom); port_sel = 1'($urandom);
            out_en = 1; data_from_cpu = 8'($urandom); hlt_en = 1; mask_we = 1;
            mask_din = 4'($urandom); intr_ack = 1;
            tick();
        end
        chk("rst out_ports", 32'(out_ports), 0);
        chk("rst data_to_cpu", 32'(data_to_cpu), 0);
        chk("rst pending", 32'(irq_pending), 0);
        chk("rst intr_flag", 32'(intr_flag), 0);
        chk("rst hlt_flag", 32'(hlt_flag), 0);
        rst = 0; in_ports = 0; irq = 0; port_sel = 0; out_en = 0; data_from_cpu = 0;
        hlt_en = 0; mask_we = 0; mask_din = 0; intr_ack = 0;
        ticks(3);
        out_en = 1; port_sel = 1; data_from_cpu = 8'hA5;
        tick();
        chk("out port1", 32'(out_ports), 32'h0000A500);
        out_en = 0; in_ports = 16'h3C5A; port_sel = 0;
        tick();
        chk("in port0", 32'(data_to_cpu), 32'h5A);
        port_sel = 1;
        tick();
        chk("in port1", 32'(data_to_cpu), 32'h3C);
        irq = 4'b1010;
        ticks(2);
        chk("pending early", 32'(irq_pending), 0);
        tick();
        chk("pending 1010", 32'(irq_pending), 32'hA);
        chk("id 1", 32'(intr_id), 1);
        chk("mask reset 1111", 32'(intr_flag), 1);
        irq = 4'b0010; intr_ack = 1;
        tick();
        chk("ack1 pending", 32'(irq_pending), 32'h8);
        chk("ack1 id 3", 32'(intr_id), 3);
        tick();
        chk("ack2 flag", 32'(intr_flag), 0);
        intr_ack = 0;
        ticks(2);
        chk("edge held no reset", 32'(irq_pending), 0);
        irq = 0;
        ticks(3);
        irq = 4'b0010;
        ticks(3);
        chk("pending 0010", 32'(irq_pending), 32'h2);
        mask_we = 1; mask_din = 4'b1101;
        tick();
        chk("masked flag", 32'(intr_flag), 0);
        chk("masked pending", 32'(irq_pending), 32'h2);
        mask_din = 4'b1111;
        tick();
        chk("unmasked flag", 32'(intr_flag), 1);
        mask_we = 0; intr_ack = 1;
        tick();
        intr_ack = 0; irq = 0;
        chk("cleared", 32'(irq_pending), 0);
        hlt_en = 1;
        tick();
        chk("halted", 32'(hlt_flag), 1);
        hlt_en = 0; irq = 4'b0100;
        ticks(3);
        chk("halt before wake", 32'(hlt_flag), 1);
        irq = 0;
        tick();
        chk("woken", 32'(hlt_flag), 0);
        hlt_en = 1;
        tick();
        chk("no halt over irq", 32'(hlt_flag), 0);
        hlt_en = 0;
        ticks(3);
        irq = 4'b0100;
        ticks(2);
        intr_ack = 1;
        tick();
        chk("set beats clear", 32'(irq_pending), 32'h4);
        tick();
        chk("later ack clears", 32'(irq_pending), 0);
        intr_ack = 0; irq = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(299) == 0);
            in_ports = 16'($urandom);
            port_sel = 1'($urandom);
            out_en = 1'($urandom);
            data_from_cpu = 8'($urandom);
            for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) irq[i] = ~irq[i];
            intr_ack = ($urandom_range(2) == 0);
            hlt_en = ($urandom_range(7) == 0);
            mask_we = ($urandom_range(15) == 0);
            mask_din = 4'($urandom);
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
